load_store_unit: RTL and testbench

- Memory-access stage of the RISC-V core, sitting between the execute stage and the load-extension stage.
- Accepts one load or store per transaction from execute and drives a valid/ready request port to data memory.
- For stores, generates write byte-enables and lane-aligned write data.
- For loads, waits for the response and hands the raw word, func3 and byte offset downstream for sign/zero extension.

---
 rtl/load_store_unit_pkg.sv | 45 ++++
 rtl/load_store_unit_if.sv | 52 +++++
 rtl/load_store_unit_store_align.sv | 39 +++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, access-size
// encodings, FSM state encoding and the misalignment helper.
package load_store_unit_pkg;

  // RISC-V funct3 encodings for loads and stores.
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB  = 3'b000;
  localparam logic [2:0] FNC_SH  = 3'b001;
  localparam logic [2:0] FNC_SW  = 3'b010;

  // Access size, taken from funct3[1:0].
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StIssue    = 2'b01,
    StWaitResp = 2'b10
  } lsu_state_e;

  // funct3[1:0] = 11 is treated as a word access.
  function automatic size_e size_of(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] offset);
    case (sz)
      SZ_H:    return offset[0];
      SZ_W:    return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the execute-side, memory-side and load-result signals of the
// load/store unit.
//   master : the load/store unit itself
//   slave  : the surrounding pipeline / memory model
interface load_store_unit_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();

  // Execute stage -> LSU
  logic                  ex_valid;
  logic                  ex_is_load;
  logic                  ex_is_store;
  logic [2:0]            ex_func3;
  logic [ADDR_WIDTH-1:0] ex_addr;
  logic [WIDTH-1:0]      ex_wdata;
  logic [4:0]            ex_rd;
  logic                  lsu_ready;

  // LSU <-> data memory
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_we;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_resp_valid;
  logic [WIDTH-1:0]      mem_resp_data;

  // LSU -> load extension / writeback
  logic                  ld_valid;
  logic [WIDTH-1:0]      ld_data_raw;
  logic [2:0]            ld_func3;
  logic [1:0]            ld_offset;
  logic [4:0]            ld_rd;
  logic                  st_done;
  logic                  misalign_exc;

  modport master (
    input  ex_valid, ex_is_load, ex_is_store, ex_func3, ex_addr, ex_wdata, ex_rd,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output lsu_ready, mem_req_valid, mem_addr, mem_we, mem_wdata,
    output ld_valid, ld_data_raw, ld_func3, ld_offset, ld_rd, st_done, misalign_exc
  );

  modport slave (
    output ex_valid, ex_is_load, ex_is_store, ex_func3, ex_addr, ex_wdata, ex_rd,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  lsu_ready, mem_req_valid, mem_addr, mem_we, mem_wdata,
    input  ld_valid, ld_data_raw, ld_func3, ld_offset, ld_rd, st_done, misalign_exc
  );

endinterface

// File: rtl/load_store_unit_store_align.sv
// Combinational store lane alignment.
//   size_i   : access size
//   offset_i : byte offset within the word
//   wdata_i  : rs2 store data
//   we_o     : byte write enables
//   wdata_o  : store data replicated onto every lane of its size
// A misaligned half uses only offset[1]; a word ignores the offset entirely.
module load_store_unit_store_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  size_e            size_i,
  input  logic [1:0]       offset_i,
  input  logic [Width-1:0] wdata_i,
  output logic [3:0]       we_o,
  output logic [Width-1:0] wdata_o
);

  always_comb begin
    we_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size_i)
      SZ_B: begin
        we_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        we_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        we_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store from execute, issues it to data
// memory over a valid/ready request, and returns load words (unextended) with
// their funct3, byte offset and destination register.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : load_store_unit_if.master (execute, memory and load-result signals)
// All outputs are registered.
// Optional feature LSU_MISALIGN_TRAP_EN: misaligned half/word ops are dropped at
// accept and misalign_exc pulses instead; otherwise misalign_exc is always 0.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  load_store_unit_if.master     bus
);

  lsu_state_e            state_q;
  logic                  is_load_q;
  logic [2:0]            func3_q;
  logic [1:0]            offset_q;
  logic [4:0]            rd_q;

  logic                  lsu_ready_q;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            we_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  ld_valid_q;
  logic [WIDTH-1:0]      ld_data_q;
  logic [2:0]            ld_func3_q;
  logic [1:0]            ld_offset_q;
  logic [4:0]            ld_rd_q;
  logic                  st_done_q;
  logic                  misalign_q;

  size_e            ex_size;
  logic [3:0]       align_we;
  logic [WIDTH-1:0] align_wdata;
  logic             accept;
  logic             trap;

  assign ex_size = size_of(bus.ex_func3);
  assign accept  = bus.ex_valid & (bus.ex_is_load | bus.ex_is_store);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(ex_size, bus.ex_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  load_store_unit_store_align #(
    .Width (WIDTH)
  ) u_store_align (
    .size_i   (ex_size),
    .offset_i (bus.ex_addr[1:0]),
    .wdata_i  (bus.ex_wdata),
    .we_o     (align_we),
    .wdata_o  (align_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      is_load_q   <= 1'b0;
      func3_q     <= '0;
      offset_q    <= '0;
      rd_q        <= '0;
      lsu_ready_q <= 1'b1;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= '0;
      wdata_q     <= '0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      ld_func3_q  <= '0;
      ld_offset_q <= '0;
      ld_rd_q     <= '0;
      st_done_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      // Pulse outputs default low.
      ld_valid_q <= 1'b0;
      st_done_q  <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (trap) begin
              misalign_q <= 1'b1;
            end else begin
              // Load wins when both flags are set.
              is_load_q   <= bus.ex_is_load;
              func3_q     <= bus.ex_func3;
              offset_q    <= bus.ex_addr[1:0];
              rd_q        <= bus.ex_rd;
              addr_q      <= {bus.ex_addr[ADDR_WIDTH-1:2], 2'b00};
              we_q        <= bus.ex_is_load ? 4'b0000 : align_we;
              wdata_q     <= bus.ex_is_load ? '0 : align_wdata;
              req_valid_q <= 1'b1;
              lsu_ready_q <= 1'b0;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          if (bus.mem_req_ready) begin
            req_valid_q <= 1'b0;
            if (is_load_q) begin
              state_q <= StWaitResp;
            end else begin
              st_done_q   <= 1'b1;
              lsu_ready_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
        end
        StWaitResp: begin
          if (bus.mem_resp_valid) begin
            ld_valid_q  <= 1'b1;
            ld_data_q   <= bus.mem_resp_data;
            ld_func3_q  <= func3_q;
            ld_offset_q <= offset_q;
            ld_rd_q     <= rd_q;
            lsu_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          req_valid_q <= 1'b0;
          lsu_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.lsu_ready     = lsu_ready_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.ld_valid      = ld_valid_q;
  assign bus.ld_data_raw   = ld_data_q;
  assign bus.ld_func3      = ld_func3_q;
  assign bus.ld_offset     = ld_offset_q;
  assign bus.ld_rd         = ld_rd_q;
  assign bus.st_done       = st_done_q;
  assign bus.misalign_exc  = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Inputs are driven and outputs sampled
// 1 ns after each rising edge.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  load_store_unit_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

  load_store_unit #(
    .WIDTH      (32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present an op in the current cycle (c0); returns in c1.
  task automatic start(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    bus.ex_valid    = 1'b1;
    bus.ex_is_load  = ld;
    bus.ex_is_store = st;
    bus.ex_func3    = f3;
    bus.ex_addr     = a;
    bus.ex_wdata    = wd;
    bus.ex_rd       = rd;
    cyc();
    bus.ex_valid    = 1'b0;
    bus.ex_is_load  = 1'b0;
    bus.ex_is_store = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd);
    start(1'b0, 1'b1, f3, a, wd, 5'd0);
    bus.mem_req_ready = 1'b1;
    check({tag, " req_valid"}, 32'(bus.mem_req_valid), 32'd1);
    check({tag, " addr"}, bus.mem_addr, {a[31:2], 2'b00});
    check({tag, " we"}, 32'(bus.mem_we), 32'(exp_we));
    check({tag, " wdata"}, bus.mem_wdata, exp_wd);
    check({tag, " busy"}, 32'(bus.lsu_ready), 32'd0);
    cyc();
    bus.mem_req_ready = 1'b0;
    check({tag, " st_done"}, 32'(bus.st_done), 32'd1);
    check({tag, " req_drop"}, 32'(bus.mem_req_valid), 32'd0);
    check({tag, " ready_back"}, 32'(bus.lsu_ready), 32'd1);
    cyc();
    check({tag, " st_done_pulse"}, 32'(bus.st_done), 32'd0);
  endtask

  task automatic do_load(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input int stall, input logic [31:0] data);
    start(ld, st, f3, a, 32'hCAFE0000, rd);
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check({tag, " stall_valid"}, 32'(bus.mem_req_valid), 32'd1);
      check({tag, " stall_addr"}, bus.mem_addr, {a[31:2], 2'b00});
      check({tag, " stall_busy"}, 32'(bus.lsu_ready), 32'd0);
      cyc();
    end
    bus.mem_req_ready  = 1'b1;
    // A response in the handshake cycle must be ignored.
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0BAD0BAD;
    check({tag, " req_valid"}, 32'(bus.mem_req_valid), 32'd1);
    check({tag, " addr"}, bus.mem_addr, {a[31:2], 2'b00});
    check({tag, " we"}, 32'(bus.mem_we), 32'd0);
    cyc();
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_data = data;
    check({tag, " no_early_ld"}, 32'(bus.ld_valid), 32'd0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    check({tag, " ld_valid"}, 32'(bus.ld_valid), 32'd1);
    check({tag, " ld_data"}, bus.ld_data_raw, data);
    check({tag, " ld_func3"}, 32'(bus.ld_func3), 32'(f3));
    check({tag, " ld_offset"}, 32'(bus.ld_offset), 32'(a[1:0]));
    check({tag, " ld_rd"}, 32'(bus.ld_rd), 32'(rd));
    check({tag, " ready_back"}, 32'(bus.lsu_ready), 32'd1);
    cyc();
    check({tag, " ld_pulse"}, 32'(bus.ld_valid), 32'd0);
    check({tag, " ld_hold"}, bus.ld_data_raw, data);
  endtask

  initial begin
    bus.ex_valid       = 1'b0;
    bus.ex_is_load     = 1'b0;
    bus.ex_is_store    = 1'b0;
    bus.ex_func3       = 3'b000;
    bus.ex_addr        = 32'h0;
    bus.ex_wdata       = 32'h0;
    bus.ex_rd          = 5'd0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    check("rst lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check("rst req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst we", 32'(bus.mem_we), 32'd0);
    check("rst ld_valid", 32'(bus.ld_valid), 32'd0);
    check("rst st_done", 32'(bus.st_done), 32'd0);
    check("rst misalign", 32'(bus.misalign_exc), 32'd0);

    do_store("SB3", 3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_store("SB1", 3'b000, 32'h0000_1001, 32'h1234_5677, 4'b0010, 32'h7777_7777);
    do_store("SH2", 3'b001, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_store("SW",  3'b010, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    do_load("LW",   1'b1, 1'b0, 3'b010, 32'h0000_3000, 5'd7, 0, 32'hDEAD_BEEF);
    do_load("LB",   1'b1, 1'b0, 3'b000, 32'h0000_4001, 5'd3, 3, 32'h1122_3344);
    do_load("LHU",  1'b1, 1'b0, 3'b101, 32'h0000_4002, 5'd9, 1, 32'h5566_7788);
    do_load("F111", 1'b1, 1'b0, 3'b111, 32'h0000_4004, 5'd31, 0, 32'h0F0F_F0F0);
    do_load("BOTH", 1'b1, 1'b1, 3'b010, 32'h0000_6000, 5'd12, 0, 32'hA1B2_C3D4);

    // ex_valid with no op flag, plus a stray response in IDLE: both ignored.
    bus.mem_resp_valid = 1'b1;
    start(1'b0, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd1);
    bus.mem_resp_valid = 1'b0;
    check("noop req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("noop lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check("idle resp ld_valid", 32'(bus.ld_valid), 32'd0);

    // Reset while waiting for a load response; a stale response follows.
    start(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 5'd5);
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h5555_AAAA;
    check("rstwait lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check("rstwait ld_valid", 32'(bus.ld_valid), 32'd0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    check("stale ld_valid", 32'(bus.ld_valid), 32'd0);
    check("stale req_valid", 32'(bus.mem_req_valid), 32'd0);

    // Reset during a stalled store request.
    start(1'b0, 1'b1, 3'b010, 32'h0000_8000, 32'h0, 5'd0);
    check("rstiss req_valid", 32'(bus.mem_req_valid), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.mem_req_ready = 1'b1;
    check("rstiss req_drop", 32'(bus.mem_req_valid), 32'd0);
    check("rstiss st_done", 32'(bus.st_done), 32'd0);
    cyc();
    bus.mem_req_ready = 1'b0;
    check("rstiss no_st_done", 32'(bus.st_done), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    start(1'b1, 1'b0, 3'b010, 32'h0000_5002, 32'h0, 5'd4);
    check("mis exc", 32'(bus.misalign_exc), 32'd1);
    check("mis req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("mis lsu_ready", 32'(bus.lsu_ready), 32'd1);
    cyc();
    check("mis exc_pulse", 32'(bus.misalign_exc), 32'd0);
    check("mis no_req", 32'(bus.mem_req_valid), 32'd0);
    check("mis no_ld", 32'(bus.ld_valid), 32'd0);
`else
    do_load("LWMIS", 1'b1, 1'b0, 3'b010, 32'h0000_5002, 5'd4, 0, 32'h0102_0304);
    check("mis exc_tied", 32'(bus.misalign_exc), 32'd0);
    do_store("SHMIS", 3'b001, 32'h0000_2001, 32'h0000_CAFE, 4'b0011, 32'hCAFE_CAFE);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
